// File: rtl/tlul_reg_responder.sv
// rtl/tlul_reg_responder.sv - TL-UL device port bridging single A requests to a one-cycle register backend strobe.
module tlul_reg_responder #(
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_valid_i,
    input  logic [2:0]    a_opcode_i,
    input  logic [2:0]    a_param_i,
    input  logic [1:0]    a_size_i,
    input  logic [7:0]    a_source_i,
    input  logic [31:0]   a_address_i,
    input  logic [3:0]    a_mask_i,
    input  logic [31:0]   a_data_i,
    output logic          a_ready_o,
    output logic          d_valid_o,
    input  logic          d_ready_i,
    output logic [2:0]    d_opcode_o,
    output logic [2:0]    d_param_o,
    output logic [1:0]    d_size_o,
    output logic [7:0]    d_source_o,
    output logic          d_sink_o,
    output logic [31:0]   d_data_o,
    output logic [15:0]   d_user_o,
    output logic          d_error_o,
    output logic          req_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic [3:0]    be_o,
    input  logic [31:0]   rdata_i,
    input  logic          error_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic          is_get_q, is_get_d;
    logic          perr_q, perr_d;
    logic [1:0]    size_q, size_d;
    logic [7:0]    source_q, source_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic       a_hs;
    logic [3:0] lanes;
    logic       perr;
    logic       access_ok;
    logic       unused_param;

    assign unused_param = ^a_param_i;

    always_comb begin
        lanes = 4'hF;
        case (a_size_i)
            2'd0:    lanes = 4'b0001 << a_address_i[1:0];
            2'd1:    lanes = 4'b0011 << a_address_i[1:0];
            default: lanes = 4'hF;
        endcase
    end

    always_comb begin
        perr = 1'b0;
        if (!(a_opcode_i == 3'd0 || a_opcode_i == 3'd1 || a_opcode_i == 3'd4)) perr = 1'b1;
        if (a_size_i > 2'd2) perr = 1'b1;
        if (a_size_i == 2'd1 && a_address_i[0]) perr = 1'b1;
        if (a_size_i == 2'd2 && a_address_i[1:0] != 2'b00) perr = 1'b1;
        if (a_address_i[31:AW] != '0) perr = 1'b1;
        if (a_opcode_i == 3'd0 && a_mask_i != lanes) perr = 1'b1;
        if (a_opcode_i == 3'd1 && (a_mask_i == 4'h0 || (a_mask_i & ~lanes) != 4'h0)) perr = 1'b1;
    end

    assign a_hs = a_valid_i && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        is_get_d   = is_get_q;
        perr_d     = perr_q;
        size_d     = size_q;
        source_d   = source_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (a_hs) begin
                    is_get_d   = (a_opcode_i == 3'd4);
                    perr_d     = perr;
                    size_d     = a_size_i;
                    source_d   = a_source_i;
                    addr_d     = a_address_i[AW-1:0];
                    mask_d     = a_mask_i;
                    wdata_d    = a_data_i;
                    rsp_err_d  = perr;
                    rsp_data_d = (perr && a_opcode_i == 3'd4) ? 32'hFFFF_FFFF : 32'h0;
                    state_d    = ACCESS;
                end
            end
            // A rejected request still spends this cycle here (strobe suppressed) so
            // its response appears one edge after the handshake.
            ACCESS: state_d = perr_q ? RESP : WAIT;
            WAIT: begin
                rsp_err_d  = error_i;
                rsp_data_d = is_get_q ? (error_i ? 32'hFFFF_FFFF : rdata_i) : 32'h0;
                state_d    = RESP;
            end
            RESP: begin
                if (d_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            is_get_q   <= 1'b0;
            perr_q     <= 1'b0;
            size_q     <= 2'd0;
            source_q   <= 8'd0;
            addr_q     <= '0;
            mask_q     <= 4'h0;
            wdata_q    <= 32'h0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_get_q   <= is_get_d;
            perr_q     <= perr_d;
            size_q     <= size_d;
            source_q   <= source_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign access_ok  = (state_q == ACCESS) && !perr_q;
    assign a_ready_o  = (state_q == IDLE);
    assign req_o      = access_ok;
    assign we_o       = access_ok && !is_get_q;
    assign be_o       = access_ok ? (is_get_q ? 4'hF : mask_q) : 4'h0;
    assign addr_o     = {addr_q[AW-1:2], 2'b00};
    assign wdata_o    = wdata_q;

    assign d_valid_o  = (state_q == RESP);
    assign d_opcode_o = {2'b00, is_get_q};
    assign d_param_o  = 3'd0;
    assign d_size_o   = size_q;
    assign d_source_o = source_q;
    assign d_sink_o   = 1'b0;
    assign d_data_o   = rsp_data_q;
    assign d_user_o   = 16'h0;
    assign d_error_o  = rsp_err_q;

endmodule

// File: tb/tb_tlul_reg_responder.sv
// tb/tb_tlul_reg_responder.sv - directed vector bench for tlul_reg_responder.
module tb_tlul_reg_responder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        a_valid_i;
    logic [2:0]  a_opcode_i, a_param_i;
    logic [1:0]  a_size_i;
    logic [7:0]  a_source_i;
    logic [31:0] a_address_i;
    logic [3:0]  a_mask_i;
    logic [31:0] a_data_i;
    logic        a_ready_o, d_valid_o, d_ready_i;
    logic [2:0]  d_opcode_o, d_param_o;
    logic [1:0]  d_size_o;
    logic [7:0]  d_source_o;
    logic        d_sink_o;
    logic [31:0] d_data_o;
    logic [15:0] d_user_o;
    logic        d_error_o, req_o, we_o;
    logic [11:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic [31:0] rdata_i;
    logic        error_i;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tlul_reg_responder #(.AW(12)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_opcode_i(a_opcode_i), .a_param_i(a_param_i),
        .a_size_i(a_size_i), .a_source_i(a_source_i), .a_address_i(a_address_i),
        .a_mask_i(a_mask_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
        .d_param_o(d_param_o), .d_size_o(d_size_o), .d_source_o(d_source_o),
        .d_sink_o(d_sink_o), .d_data_o(d_data_o), .d_user_o(d_user_o),
        .d_error_o(d_error_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata_i), .error_i(error_i)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [7:0]  src;
        logic [31:0] rdata;
        logic        err_in;
        logic        perr;
        logic        we;
        logic [3:0]  be;
        logic [11:0] eaddr;
        logic        dop;
        logic [31:0] ddata;
        logic        derr;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        a_valid_i   = 1'b1;
        a_opcode_i  = op;
        a_size_i    = size;
        a_address_i = addr;
        a_mask_i    = mask;
        a_data_i    = data;
        a_source_i  = src;
    endtask

    initial begin
        //          op    sz    addr          mask   data          src    rdata         ei    perr  we    be     eaddr    dop   ddata         derr
        vecs[0]  = '{3'd4, 2'd2, 32'h0000_0010, 4'hF, 32'h0,        8'h5A, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 4'hF, 12'h010, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{3'd1, 2'd0, 32'h0000_0007, 4'h8, 32'h11223344, 8'h21, 32'h0,        1'b0, 1'b0, 1'b1, 4'h8, 12'h004, 1'b0, 32'h0,        1'b0};
        vecs[2]  = '{3'd0, 2'd2, 32'h0000_0020, 4'h7, 32'h99,       8'h22, 32'h0,        1'b0, 1'b1, 1'b0, 4'h0, 12'h020, 1'b0, 32'h0,        1'b1};
        vecs[3]  = '{3'd4, 2'd2, 32'h0000_1000, 4'hF, 32'h0,        8'h23, 32'h0,        1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{3'd4, 2'd2, 32'h0000_0004, 4'hF, 32'h0,        8'h24, 32'h12345678, 1'b1, 1'b0, 1'b0, 4'hF, 12'h004, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{3'd0, 2'd1, 32'h0000_0002, 4'hC, 32'hAABBCCDD, 8'h25, 32'h0,        1'b0, 1'b0, 1'b1, 4'hC, 12'h000, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{3'd4, 2'd3, 32'h0000_0000, 4'hF, 32'h0,        8'h26, 32'h0,        1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{3'd4, 2'd1, 32'h0000_0003, 4'hF, 32'h0,        8'h27, 32'h0,        1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{3'd2, 2'd2, 32'h0000_0000, 4'hF, 32'h0,        8'h28, 32'h0,        1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b0, 32'h0,        1'b1};
        vecs[9]  = '{3'd1, 2'd2, 32'h0000_0000, 4'h0, 32'h0,        8'h29, 32'h0,        1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{3'd1, 2'd1, 32'h0000_0000, 4'h4, 32'h0,        8'h2A, 32'h0,        1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{3'd0, 2'd2, 32'h0000_0FFC, 4'hF, 32'h5,        8'h2B, 32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 12'hFFC, 1'b0, 32'h0,        1'b1};
        vecs[12] = '{3'd1, 2'd2, 32'h0000_0008, 4'h5, 32'h0A0B0C0D, 8'h2C, 32'h0,        1'b0, 1'b0, 1'b1, 4'h5, 12'h008, 1'b0, 32'h0,        1'b0};
        vecs[13] = '{3'd4, 2'd0, 32'h0000_0003, 4'h8, 32'h0,        8'h2D, 32'h55667788, 1'b0, 1'b0, 1'b0, 4'hF, 12'h000, 1'b1, 32'h55667788, 1'b0};

        rst_i = 1'b1; a_valid_i = 1'b0; a_opcode_i = 3'd0; a_param_i = 3'd0; a_size_i = 2'd0;
        a_source_i = 8'd0; a_address_i = 32'd0; a_mask_i = 4'd0; a_data_i = 32'd0;
        d_ready_i = 1'b1; rdata_i = 32'd0; error_i = 1'b0;
        step(); step();
        chk("rst d_valid", d_valid_o, 0);
        chk("rst req", req_o, 0);
        chk("rst we", we_o, 0);
        chk("rst be", be_o, 0);
        chk("rst d_data", d_data_o, 0);
        chk("rst d_error", d_error_o, 0);
        chk("rst d_opcode", d_opcode_o, 0);
        chk("rst d_size", d_size_o, 0);
        chk("rst d_source", d_source_o, 0);
        chk("rst addr", addr_o, 0);
        chk("rst wdata", wdata_o, 0);
        rst_i = 1'b0;
        step();
        chk("rst a_ready", a_ready_o, 1);

        for (int i = 0; i < 14; i++) begin
            chk($sformatf("v%0d a_ready idle", i), a_ready_o, 1);
            drive_a(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].src);
            rdata_i = vecs[i].rdata;
            error_i = vecs[i].err_in;
            d_ready_i = 1'b1;
            step();
            a_valid_i = 1'b0;
            chk($sformatf("v%0d a_ready busy", i), a_ready_o, 0);
            chk($sformatf("v%0d d_valid k", i), d_valid_o, 0);
            if (!vecs[i].perr) begin
                chk($sformatf("v%0d req", i), req_o, 1);
                chk($sformatf("v%0d we", i), we_o, vecs[i].we);
                chk($sformatf("v%0d be", i), be_o, vecs[i].be);
                chk($sformatf("v%0d addr", i), addr_o, vecs[i].eaddr);
                chk($sformatf("v%0d wdata", i), wdata_o, vecs[i].data);
                step();
                chk($sformatf("v%0d req wait", i), req_o, 0);
                chk($sformatf("v%0d d_valid wait", i), d_valid_o, 0);
            end else begin
                chk($sformatf("v%0d no req", i), req_o, 0);
            end
            step();
            chk($sformatf("v%0d d_valid", i), d_valid_o, 1);
            chk($sformatf("v%0d req resp", i), req_o, 0);
            chk($sformatf("v%0d d_opcode", i), d_opcode_o, {2'b00, vecs[i].dop});
            chk($sformatf("v%0d d_data", i), d_data_o, vecs[i].ddata);
            chk($sformatf("v%0d d_error", i), d_error_o, vecs[i].derr);
            chk($sformatf("v%0d d_source", i), d_source_o, vecs[i].src);
            chk($sformatf("v%0d d_size", i), d_size_o, vecs[i].size);
            chk($sformatf("v%0d d_zero", i), {d_param_o, d_sink_o, d_user_o}, 0);
            step();
            chk($sformatf("v%0d d_valid done", i), d_valid_o, 0);
            chk($sformatf("v%0d a_ready again", i), a_ready_o, 1);
        end

        // Backpressure: erroring Get held in RESP while a new request is offered.
        drive_a(3'd4, 2'd2, 32'h18, 4'hF, 32'h0, 8'h33);
        rdata_i = 32'hCAFEF00D; error_i = 1'b1; d_ready_i = 1'b0;
        step();
        a_valid_i = 1'b0;
        step(); step();
        chk("bp d_valid", d_valid_o, 1);
        for (int c = 0; c < 5; c++) begin
            drive_a(3'd4, 2'd2, 32'h40, 4'hF, 32'h0, 8'h77);
            error_i = 1'b0;
            step();
            chk($sformatf("bp%0d d_valid", c), d_valid_o, 1);
            chk($sformatf("bp%0d a_ready", c), a_ready_o, 0);
            chk($sformatf("bp%0d req", c), req_o, 0);
            chk($sformatf("bp%0d d_data", c), d_data_o, 32'hFFFFFFFF);
            chk($sformatf("bp%0d d_error", c), d_error_o, 1);
            chk($sformatf("bp%0d d_source", c), d_source_o, 8'h33);
            chk($sformatf("bp%0d d_opcode", c), d_opcode_o, 3'd1);
        end
        a_valid_i = 1'b0;
        d_ready_i = 1'b1;
        step();
        chk("bp release a_ready", a_ready_o, 1);
        chk("bp release d_valid", d_valid_o, 0);
        step();
        chk("bp no stray req", req_o, 0);

        // Reset pulsed while the backend access is in WAIT.
        drive_a(3'd4, 2'd2, 32'h2C, 4'hF, 32'h0, 8'h44);
        rdata_i = 32'h0BADC0DE; error_i = 1'b1;
        step();
        a_valid_i = 1'b0;
        chk("rw req", req_o, 1);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rw a_ready", a_ready_o, 1);
        chk("rw d_valid", d_valid_o, 0);
        chk("rw d_error", d_error_o, 0);
        chk("rw d_data", d_data_o, 0);
        chk("rw d_source", d_source_o, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rw%0d no resp", c), d_valid_o, 0);
            chk($sformatf("rw%0d no req", c), req_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
